// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg -- shared MIPS definitions used by the instruction fetch unit.
//   * Default reset PC and exception vector
//   * Exception codes written into ExcCode_D
//   * Instruction memory address window (0x3000..0x4ffc)
//   * Helper for the sequential next-PC computation
// -----------------------------------------------------------------------------
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    localparam logic [4:0]  EXC_NONE     = 5'd0;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    localparam logic [31:0] IM_ADDR_LO   = 32'h0000_3000;
    localparam logic [31:0] IM_ADDR_HI   = 32'h0000_4ffc;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Sequential successor; the carry out of bit 31 is dropped so
    // 32'hFFFF_FFFC wraps to zero.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifu_pc.sv
// -----------------------------------------------------------------------------
// ifu_pc -- fetch-stage PC register and next-PC selection.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   exc_req, eret_req     exception entry / return redirect (override stall)
//   epc                   eret return address
//   stall                 hold the PC
//   br_taken, br_target   branch/jump resolved in D and its target
//   pc_f                  current fetch PC (registered)
//   pc_next               selected next PC (combinational)
//   redirect              exc_req or eret_req is steering the next PC
// Targets are taken as-is; misaligned or out-of-window addresses are
// reported by the instruction memory on the following fetch.
// -----------------------------------------------------------------------------
module ifu_pc
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_f,
    output logic [31:0] pc_next,
    output logic        redirect
);

    // Next-PC priority: exception, eret, stall hold, branch, sequential.
    always_comb begin
        pc_next  = pc_incr(pc_f);
        redirect = exc_req | eret_req;
        if (exc_req) begin
            pc_next = EXC_VEC;
        end else if (eret_req) begin
            pc_next = epc;
        end else if (stall) begin
            pc_next = pc_f;
        end else if (br_taken) begin
            pc_next = br_target;
        end else begin
            pc_next = pc_incr(pc_f);
        end
    end

    // PC register; reset forces the first fetch to RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

endmodule

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- MIPS instruction fetch unit: PC (ifu_pc) plus the F/D pipeline
// register and an optional fetch counter.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   IM_PC / IM_Instr / IM_AdEL instruction memory address, data, address error
//   Stall                      hold PC and F/D register
//   Br_Taken, Br_Target        branch/jump redirect resolved in D
//   Is_Jump_D                  next fetched word is a delay slot (sets BD_D)
//   Exc_Req, Eret_Req, EPC     exception entry / return and return address
//   Instr_D, PC_D, Valid_D,
//   ExcCode_D, BD_D            F/D register outputs
//   Fetch_Cnt                  words loaded into D
// Build option: define IFU_FETCH_CNT_EN to enable the Fetch_Cnt counter;
// otherwise Fetch_Cnt is tied to zero.
// -----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IM_PC,
    input  logic [31:0] IM_Instr,
    input  logic        IM_AdEL,
    input  logic        Stall,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Target,
    input  logic        Is_Jump_D,
    input  logic        Exc_Req,
    input  logic        Eret_Req,
    input  logic [31:0] EPC,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic        Valid_D,
    output logic [4:0]  ExcCode_D,
    output logic        BD_D,
    output logic [31:0] Fetch_Cnt
);

    logic [31:0] pc_f_s;
    logic [31:0] pc_next_s;
    logic        redirect_s;
    logic        advance_s;

    ifu_pc #(
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .exc_req   (Exc_Req),
        .eret_req  (Eret_Req),
        .epc       (EPC),
        .stall     (Stall),
        .br_taken  (Br_Taken),
        .br_target (Br_Target),
        .pc_f      (pc_f_s),
        .pc_next   (pc_next_s),
        .redirect  (redirect_s)
    );

    assign IM_PC = pc_f_s;

    // A word enters D only when nothing redirects and nothing stalls.
    assign advance_s = ~redirect_s & ~Stall;

    // F/D register: flush on redirect, hold on stall, else load the fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Instr_D   <= NOP_INSTR;
            PC_D      <= 32'h0000_0000;
            Valid_D   <= 1'b0;
            ExcCode_D <= EXC_NONE;
            BD_D      <= 1'b0;
        end else if (redirect_s) begin
            // PC_D tracks the redirect target so a flushed slot still
            // carries a meaningful address.
            Instr_D   <= NOP_INSTR;
            PC_D      <= pc_next_s;
            Valid_D   <= 1'b0;
            ExcCode_D <= EXC_NONE;
            BD_D      <= 1'b0;
        end else if (Stall) begin
            Instr_D   <= Instr_D;
            PC_D      <= PC_D;
            Valid_D   <= Valid_D;
            ExcCode_D <= ExcCode_D;
            BD_D      <= BD_D;
        end else begin
            // A faulting fetch is replaced by a nop tagged with AdEL.
            Instr_D   <= IM_AdEL ? NOP_INSTR : IM_Instr;
            PC_D      <= pc_f_s;
            Valid_D   <= 1'b1;
            ExcCode_D <= IM_AdEL ? EXC_ADEL : EXC_NONE;
            BD_D      <= Is_Jump_D;
        end
    end

`ifdef IFU_FETCH_CNT_EN
    // Fetch counter: counts every load into D, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Fetch_Cnt <= 32'h0000_0000;
        end else if (advance_s) begin
            Fetch_Cnt <= Fetch_Cnt + 32'd1;
        end else begin
            Fetch_Cnt <= Fetch_Cnt;
        end
    end
`else
    assign Fetch_Cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu -- directed self-checking bench for ifu.
// The instruction memory is modelled here: data = address ^ 32'hC0DE_0000,
// AdEL for misaligned or out-of-window addresses.
// -----------------------------------------------------------------------------
module tb_ifu;

    logic        clk;
    logic        reset;
    logic [31:0] IM_PC;
    logic [31:0] IM_Instr;
    logic        IM_AdEL;
    logic        Stall;
    logic        Br_Taken;
    logic [31:0] Br_Target;
    logic        Is_Jump_D;
    logic        Exc_Req;
    logic        Eret_Req;
    logic [31:0] EPC;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic        Valid_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D;
    logic [31:0] Fetch_Cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    ifu dut (
        .clk       (clk),
        .reset     (reset),
        .IM_PC     (IM_PC),
        .IM_Instr  (IM_Instr),
        .IM_AdEL   (IM_AdEL),
        .Stall     (Stall),
        .Br_Taken  (Br_Taken),
        .Br_Target (Br_Target),
        .Is_Jump_D (Is_Jump_D),
        .Exc_Req   (Exc_Req),
        .Eret_Req  (Eret_Req),
        .EPC       (EPC),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .Valid_D   (Valid_D),
        .ExcCode_D (ExcCode_D),
        .BD_D      (BD_D),
        .Fetch_Cnt (Fetch_Cnt)
    );

    // Instruction memory model
    assign IM_Instr = IM_PC ^ KEY;
    assign IM_AdEL  = (IM_PC[1:0] != 2'b00) || (IM_PC < 32'h0000_3000) ||
                      (IM_PC > 32'h0000_4ffc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef IFU_FETCH_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Check fetch address and every F/D output plus the counter.
    task automatic chk_all(input string tag, input logic [31:0] e_im, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic e_valid,
                           input logic [4:0] e_exc, input logic e_bd);
        chk({tag, ".IM_PC"},     IM_PC, e_im);
        chk({tag, ".Instr_D"},   Instr_D, e_instr);
        chk({tag, ".PC_D"},      PC_D, e_pcd);
        chk({tag, ".Valid_D"},   {31'd0, Valid_D}, {31'd0, e_valid});
        chk({tag, ".ExcCode_D"}, {27'd0, ExcCode_D}, {27'd0, e_exc});
        chk({tag, ".BD_D"},      {31'd0, BD_D}, {31'd0, e_bd});
        chk({tag, ".Fetch_Cnt"}, Fetch_Cnt, cnt_exp());
    endtask

    // One clock with the current inputs; tracks expected counter.
    task automatic step();
        if (!Exc_Req && !Eret_Req && !Stall) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Br_Taken = 1'b0; Br_Target = 32'd0;
        Is_Jump_D = 1'b0; Exc_Req = 1'b0; Eret_Req = 1'b0; EPC = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h3000, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;

        // Straight-line fetch
        chk("seq0.IM_PC", IM_PC, 32'h3000);
        step();
        chk_all("seq1", 32'h3004, 32'h3000 ^ KEY, 32'h3000, 1'b1, 5'd0, 1'b0);
        step();
        chk_all("seq2", 32'h3008, 32'h3004 ^ KEY, 32'h3004, 1'b1, 5'd0, 1'b0);
        step();
        step();
        chk("seq4.IM_PC", IM_PC, 32'h3010);

        // Branch with delay slot
        Br_Taken = 1'b1; Br_Target = 32'h3100; Is_Jump_D = 1'b1;
        step();
        Br_Taken = 1'b0; Is_Jump_D = 1'b0;
        chk_all("branch", 32'h3100, 32'h3010 ^ KEY, 32'h3010, 1'b1, 5'd0, 1'b1);

        // Two-cycle stall, then resume
        Stall = 1'b1;
        step();
        chk_all("stall1", 32'h3100, 32'h3010 ^ KEY, 32'h3010, 1'b1, 5'd0, 1'b1);
        step();
        chk_all("stall2", 32'h3100, 32'h3010 ^ KEY, 32'h3010, 1'b1, 5'd0, 1'b1);
        Stall = 1'b0;
        step();
        chk_all("resume", 32'h3104, 32'h3100 ^ KEY, 32'h3100, 1'b1, 5'd0, 1'b0);

        // Unaligned target produces AdEL on the next fetch
        Br_Taken = 1'b1; Br_Target = 32'h3002;
        step();
        Br_Taken = 1'b0;
        chk("unal.IM_PC", IM_PC, 32'h3002);
        step();
        chk_all("adel", 32'h3006, 32'd0, 32'h3002, 1'b1, 5'd4, 1'b0);

        // Exception beats eret and stall
        Exc_Req = 1'b1; Eret_Req = 1'b1; Stall = 1'b1; EPC = 32'h3200;
        step();
        Exc_Req = 1'b0;
        chk_all("exc", 32'h4180, 32'd0, 32'h4180, 1'b0, 5'd0, 1'b0);

        // Eret overrides stall
        step();
        Eret_Req = 1'b0; Stall = 1'b0;
        chk_all("eret", 32'h3200, 32'd0, 32'h3200, 1'b0, 5'd0, 1'b0);
        step();
        chk_all("post_eret", 32'h3204, 32'h3200 ^ KEY, 32'h3200, 1'b1, 5'd0, 1'b0);

        // PC wraps from 0xFFFF_FFFC to 0
        Br_Taken = 1'b1; Br_Target = 32'hFFFF_FFFC;
        step();
        Br_Taken = 1'b0;
        chk("wrap0.IM_PC", IM_PC, 32'hFFFF_FFFC);
        step();
        chk_all("wrap1", 32'h0000_0000, 32'd0, 32'hFFFF_FFFC, 1'b1, 5'd4, 1'b0);

        // Asynchronous reset mid-cycle during a branch
        Br_Taken = 1'b1; Br_Target = 32'h3100; Is_Jump_D = 1'b1;
        #3;
        reset = 1'b1;
        exp_cnt = 32'd0;
        #1;
        chk_all("areset", 32'h3000, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #2;
        Br_Taken = 1'b0; Is_Jump_D = 1'b0;
        chk("areset_hold.IM_PC", IM_PC, 32'h3000);
        reset = 1'b0;
        step();
        chk_all("after_reset", 32'h3004, 32'h3000 ^ KEY, 32'h3000, 1'b1, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
